spwm_multi_gen: RTL and testbench

//  Multi-channel sine-modulated PWM generator; parametrised successor of the single-channel fixed-table PWM.
//  - Steps a shared index through a run-time writable duty table.
//  - Each channel reads the table at a fixed phase offset from the shared index.
//  - Supports continuous sweeps, or sweeps separated by a programmable low gap.
//  - Drives motor/LED driver pins on DE0-Nano GPIO.

---
 rtl/spwm_multi_gen.sv | 218 +++++++++++++++++++++
 tb/tb_spwm_multi_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spwm_multi_gen.sv
// Multi-channel sine-modulated PWM: shared table index, per-channel phase offset, optional gap between sweeps.
// Optional complementary outputs with dead-time when SPWM_COMPLEMENT_EN is defined.

module spwm_lane #(
  parameter int CNT_W    = 13
`ifdef SPWM_COMPLEMENT_EN
  , parameter int DEADTIME = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             latch_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] tbl_val_i,
  output logic             pwm_o
`ifdef SPWM_COMPLEMENT_EN
  , output logic           pwm_n_o
`endif
);
  logic [CNT_W-1:0] duty_q, duty_eff;
  logic             raw_q, raw_d;

  // The compare on the latch cycle must already see the new period's duty.
  assign duty_eff = latch_i ? tbl_val_i : duty_q;
  assign raw_d    = run_i && (cnt_i < duty_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      raw_q  <= 1'b0;
    end else begin
      if (latch_i) duty_q <= tbl_val_i;
      raw_q <= raw_d;
    end
  end

`ifdef SPWM_COMPLEMENT_EN
  localparam int DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  logic [DT_W-1:0] dt_q, dt_d;
  logic            run_q;

  always_comb begin
    dt_d = dt_q;
    if (raw_d != raw_q)   dt_d = DT_W'(DEADTIME);
    else if (dt_q != '0)  dt_d = dt_q - DT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q  <= '0;
      run_q <= 1'b0;
    end else begin
      dt_q  <= dt_d;
      run_q <= run_i;
    end
  end

  assign pwm_o   = raw_q && (dt_q == '0);
  assign pwm_n_o = run_q && !raw_q && (dt_q == '0);
`else
  assign pwm_o = raw_q;
`endif
endmodule

module spwm_multi_gen #(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 13,
  parameter int PERIOD    = 5000,
  parameter int STEPS     = 89,
  parameter int AW        = 7,
  parameter int PHASE_OFS = 22,
  parameter int DEADTIME  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [31:0]         div_i,
  input  logic [15:0]         gap_i,
  input  logic                tbl_we_i,
  input  logic [AW-1:0]       tbl_addr_i,
  input  logic [CNT_W-1:0]    tbl_data_i,
  output logic [CHANNELS-1:0] pwm_o,
`ifdef SPWM_COMPLEMENT_EN
  output logic [CHANNELS-1:0] pwm_n_o,
`endif
  output logic                sweep_done_o,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      step_q, step_d, div_m;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      gap_q, gap_d;
  logic             sd_q, sd_d;
  logic             tick, busy, latch;
  logic [CNT_W-1:0] mem_q [STEPS];

  // Marker block only elaborates for an illegal parameter set.
  if (PHASE_OFS >= STEPS || PERIOD >= (1 << CNT_W) || DEADTIME < 0) begin : g_cfg_invalid
  end

  assign div_m = (div_i == '0) ? 32'd1 : div_i;
  assign tick  = (step_q >= div_m - 32'd1);
  assign busy  = (state_q != IDLE);
  assign latch = busy && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sd_d    = 1'b0;
    if (busy) begin
      step_d = tick ? '0 : step_q + 32'd1;
      cnt_d  = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN: if (tick) begin
        if (idx_q == AW'(STEPS - 1)) begin
          idx_d = '0;
          sd_d  = 1'b1;
          if (gap_i != '0) begin
            state_d = GAP;
            gap_d   = gap_i;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      GAP: if (tick) begin
        if (gap_q <= 16'd1) begin
          state_d = RUN;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable overrides everything, including a coincident wrap.
    if (!en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      step_d  = '0;
      cnt_d   = '0;
      gap_d   = '0;
      sd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sd_q    <= sd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else if (tbl_we_i) begin
      for (int i = 0; i < STEPS; i++)
        if (tbl_addr_i == AW'(i)) mem_q[i] <= tbl_data_i;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int OFS = (c * PHASE_OFS) % STEPS;
    logic [AW:0]      sum, addr;
    logic [CNT_W-1:0] val;

    always_comb begin
      sum  = {1'b0, idx_q} + (AW+1)'(OFS);
      addr = (sum >= (AW+1)'(STEPS)) ? sum - (AW+1)'(STEPS) : sum;
      val  = '0;
      for (int i = 0; i < STEPS; i++)
        if (addr == (AW+1)'(i)) val = mem_q[i];
    end

    spwm_lane #(
      .CNT_W(CNT_W)
`ifdef SPWM_COMPLEMENT_EN
      , .DEADTIME(DEADTIME)
`endif
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (state_q == RUN),
      .latch_i   (latch),
      .cnt_i     (cnt_q),
      .tbl_val_i (val),
      .pwm_o     (pwm_o[c])
`ifdef SPWM_COMPLEMENT_EN
      , .pwm_n_o (pwm_n_o[c])
`endif
    );
  end

  assign sweep_done_o = sd_q;
  assign busy_o       = busy;
endmodule

// File: tb/tb_spwm_multi_gen.sv
// Bench for spwm_multi_gen: table-driven sweep profile, hand-written corner sequences, randomized runs vs. an arithmetic model.
// AW is 3 so that table addresses at or beyond STEPS can be driven.
module tb_spwm_multi_gen;
  localparam int CH = 2, CW = 13, PER = 10, ST = 4, AW = 3, OFS = 1, DT = 2;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, we = 1'b0;
  logic [31:0]   div = '0;
  logic [15:0]   gap = '0;
  logic [AW-1:0] addr = '0;
  logic [CW-1:0] data = '0;
  logic [CH-1:0] pwm;
  logic          sd, busy;
`ifdef SPWM_COMPLEMENT_EN
  logic [CH-1:0] pwm_n;
`endif

  int n_chk = 0, n_fail = 0;
  int tbl [ST];

  always #5 clk = ~clk;

  spwm_multi_gen #(.CHANNELS(CH), .CNT_W(CW), .PERIOD(PER), .STEPS(ST), .AW(AW),
                   .PHASE_OFS(OFS), .DEADTIME(DT)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .div_i(div), .gap_i(gap),
    .tbl_we_i(we), .tbl_addr_i(addr), .tbl_data_i(data),
    .pwm_o(pwm),
`ifdef SPWM_COMPLEMENT_EN
    .pwm_n_o(pwm_n),
`endif
    .sweep_done_o(sd), .busy_o(busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: step number = n/div, sweep = STEPS run steps + gap steps,
  // duty taken from the index in force at the start of the current period.
  function automatic logic m_pwm(int n, int c, int d, int g);
    int dd  = (d == 0) ? 1 : d;
    int L   = ST + g;
    int p   = n - (n % PER);
    int sp  = (p / dd) % L;
    int idx = (sp < ST) ? sp : 0;
    logic run = ((n / dd) % L) < ST;
    return run && ((n % PER) < tbl[(idx + c * OFS) % ST]);
  endfunction

  function automatic logic m_sd(int n, int d, int g);
    int dd = (d == 0) ? 1 : d;
    return (((n + 1) % dd) == 0) && (((n / dd) % (ST + g)) == ST - 1);
  endfunction

  task automatic wr(input int a, input int v);
    @(negedge clk); we = 1'b1; addr = AW'(a); data = CW'(v);
    @(negedge clk); we = 1'b0;
    if (a < ST) tbl[a] = v;
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3);
    wr(0, v0); wr(1, v1); wr(2, v2); wr(3, v3);
  endtask

  // Sample j at the negedge after edge j; pwm there reflects PWM cycle n = j-1.
  task automatic run_check(input int d, input int g, input int ncyc);
    div = d; gap = g; en = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      check("busy_run", busy, 1);
      for (int c = 0; c < CH; c++)
        check($sformatf("pwm%0d d=%0d g=%0d j=%0d", c, d, g, j), pwm[c], (j == 0) ? 1'b0 : m_pwm(j - 1, c, d, g));
      check($sformatf("sweep_done d=%0d g=%0d j=%0d", d, g, j), sd, (j == 0) ? 1'b0 : m_sd(j - 1, d, g));
    end
  endtask

  task automatic stop();
    en = 1'b0;
    @(negedge clk); check("busy_after_1", busy, 0); check("sd_after_stop", sd, 0);
    @(negedge clk); check("pwm_after_2", pwm, 0);
  endtask

  typedef struct { int period; int hi0; int hi1; } vec_t;
  vec_t vec [8];

  initial begin
    int hi [CH][16];
    int sd_cnt, sd_first;
    int h4, h5, h6, h7;
    for (int i = 0; i < ST; i++) tbl[i] = 0;
    vec[0] = '{0, 0, 5};  vec[1] = '{1, 0, 5};  vec[2] = '{2, 5, 10}; vec[3] = '{3, 5, 10};
    vec[4] = '{4, 10, 5}; vec[5] = '{5, 10, 5}; vec[6] = '{6, 5, 0};  vec[7] = '{7, 5, 0};

    // Reset held with en high
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0); check("rst_pwm", pwm, 0); check("rst_sd", sd, 0);
    rst_n = 1'b1;
    @(negedge clk); check("busy_first_edge", busy, 1); check("pwm_first_edge", pwm, 0);
    @(negedge clk); check("pwm_first_valid_zero_table", pwm, 0);
    stop();

    // Continuous sweep profile, two sweeps
    load(0, 5, 10, 5);
    div = 20; gap = 0; en = 1'b1;
    foreach (hi[c, m]) hi[c][m] = 0;
    sd_cnt = 0; sd_first = -1;
    for (int j = 0; j <= 160; j++) begin
      @(negedge clk);
      if (sd) begin sd_cnt++; if (sd_first < 0) sd_first = j; end
      if (j >= 1) for (int c = 0; c < CH; c++) if (pwm[c]) hi[c][(j - 1) / PER]++;
    end
    stop();
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 2; s++) begin
        check($sformatf("hi0 period %0d", vec[i].period + 8 * s), hi[0][vec[i].period + 8 * s], vec[i].hi0);
        check($sformatf("hi1 period %0d", vec[i].period + 8 * s), hi[1][vec[i].period + 8 * s], vec[i].hi1);
      end
    end
    check("sweep_done_count", sd_cnt, 2);
    check("sweep_done_first", sd_first, 80);

    // Gapped sweeps
    run_check(20, 2, 260);
    stop();

    // Mid-period write, out-of-range write, write coincident with the latch
    div = 20; gap = 0; en = 1'b1;
    h4 = 0; h5 = 0; h6 = 0; h7 = 0;
    for (int j = 0; j <= 80; j++) begin
      @(negedge clk);
      if (j >= 1 && pwm[0]) begin
        case ((j - 1) / PER)
          4: h4++; 5: h5++; 6: h6++; 7: h7++; default: ;
        endcase
      end
      we = 1'b0;
      if (j == 44) begin we = 1'b1; addr = 3'd2; data = 13'd3; end
      if (j == 47) begin we = 1'b1; addr = 3'd5; data = 13'd9; end
      if (j == 60) begin we = 1'b1; addr = 3'd3; data = 13'd7; end
    end
    we = 1'b0;
    stop();
    tbl[2] = 3; tbl[3] = 7;
    check("write_mid_period_keeps", h4, 10);
    check("write_next_latch", h5, 3);
    check("write_at_latch_old", h6, 5);
    check("write_at_latch_new", h7, 7);
    wr(4, 11); wr(7, 12);
    run_check(20, 0, 90);
    stop();

    // div=0, en drop while high, restart at idx 0
    run_check(0, 0, 40);
    stop();
    load(10, 10, 10, 10);
    run_check(0, 0, 25);
    check("pwm_high_before_drop", pwm[0], 1);
    stop();
    load(1, 4, 7, 9);
    run_check(0, 0, 30);
    stop();
    run_check(0, 1, 45);
    stop();

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      load($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
      run_check($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(40, 150));
      stop();
    end

`ifdef SPWM_COMPLEMENT_EN
    begin
      int hp, hn, both_lo, ovl;
      load(5, 5, 5, 5);
      div = 100; gap = 0; en = 1'b1;
      hp = 0; hn = 0; both_lo = 0; ovl = 0;
      for (int j = 0; j <= 40; j++) begin
        @(negedge clk);
        if (pwm[0] && pwm_n[0]) ovl++;
        if (j >= 21 && j <= 30) begin
          if (pwm[0]) hp++;
          if (pwm_n[0]) hn++;
          if (!pwm[0] && !pwm_n[0]) both_lo++;
        end
      end
      stop();
      check("dt_pwm_high", hp, 3);
      check("dt_pwm_n_high", hn, 3);
      check("dt_both_low", both_lo, 4);
      check("dt_no_overlap", ovl, 0);
      check("dt_pwm_n_idle", pwm_n, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
